// File: rtl/mips_program_loader.sv
// Instruction encoder/loader: packs symbolic MIPS instructions into 32-bit words
// and streams them into instruction memory through a one-entry encode stage.
module mips_program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  imem_we,
    input  logic                  imem_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  err_illegal,
    output logic                  err_overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        K_LW   = 3'd0,
        K_SW   = 3'd1,
        K_R    = 3'd2,
        K_ADDI = 3'd3,
        K_BEQ  = 3'd4,
        K_J    = 3'd5
    } kind_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [31:0]           stage_word;
    logic                  stage_full;
    logic                  last_seen;

    logic write;
    logic accept;
    logic legal;
    logic at_max;
    logic overflow_set;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        case (kind)
            K_LW:    encode = {6'b100011, rs, rt, imm};
            K_SW:    encode = {6'b101011, rs, rt, imm};
            K_R:     encode = {6'b000000, rs, rt, rd, shamt, funct};
            K_ADDI:  encode = {6'b001000, rs, rt, imm};
            K_BEQ:   encode = {6'b000100, rs, rt, imm};
            K_J:     encode = {6'b000010, target};
            default: encode = '0;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n      = state;
        at_max       = (ptr == ADDR_MAX);
        write        = stage_full & imem_ready;
        legal        = (in_kind <= K_J);
        // The stage may refill in the same cycle it drains, except when the
        // pending word already occupies the last address.
        in_ready     = (state == S_LOAD) & ~last_seen
                     & (~stage_full | write)
                     & ~(at_max & stage_full);
        accept       = in_valid & in_ready;
        overflow_set = (state == S_LOAD) & write & at_max;

        case (state)
            S_IDLE:  if (start) state_n = S_LOAD;
            S_LOAD: begin
                if (accept && in_last) state_n = S_DRAIN;
                else if (overflow_set) state_n = S_DRAIN;
            end
            S_DRAIN: if (!stage_full) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ptr          <= BASE;
            stage_word   <= '0;
            stage_full   <= 1'b0;
            last_seen    <= 1'b0;
            word_count   <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && start) begin
                ptr          <= BASE;
                word_count   <= '0;
                err_illegal  <= 1'b0;
                err_overflow <= 1'b0;
                last_seen    <= 1'b0;
            end else begin
                if (write) begin
                    ptr        <= ptr + PTR_ONE;
                    word_count <= word_count + COUNT_ONE;
                    stage_full <= 1'b0;
                end
                // A same-cycle refill overrides the drain above.
                if (accept && legal) begin
                    stage_word <= encode(in_kind, in_rs, in_rt, in_rd, in_shamt,
                                         in_funct, in_imm, in_target);
                    stage_full <= 1'b1;
                end
                if (accept && !legal) err_illegal <= 1'b1;
                if (accept && in_last) last_seen <= 1'b1;
                if (overflow_set) err_overflow <= 1'b1;
            end
        end
    end

    assign imem_we    = stage_full;
    assign imem_addr  = ptr;
    assign imem_wdata = stage_word;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule
